// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer front end and the downstream
// Moore sequence detector fed by the serial line w.
package bit_serializer_pkg;

  // Serializer control states; a single bit is enough for two states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Default word geometry and the level driven on w between words.
  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  // Downstream detector states: count consecutive 1s seen on w and saturate.
  // z is raised while the detector sits in DET_S3, i.e. after three 1s in a row.
  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;
  localparam logic [1:0] DET_S3 = 2'd3;

  // Width of a counter that has to index every bit of a word; never below 1.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// drives them one bit per clock onto w. A one-word holding register lets a
// second word be queued so consecutive words stream with no idle gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] sh_shifted_s;

  // Handshake, shift direction and the externally visible status outputs.
  // Ready depends only on registered state, never on din_valid.
  always_comb begin
    din_ready  = !hold_full_q;
    accept_s   = din_valid && !hold_full_q;
    last_bit_s = (cnt_q == CNT_LAST);
    if (MSB_FIRST) begin
      sh_shifted_s = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      sh_shifted_s = {1'b0, sh_q[WIDTH-1:1]};
    end
    w_valid   = (state_q == SHIFT);
    if (w_valid) begin
      w = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    end else begin
      w = IDLE_LEVEL;
    end
    word_done = w_valid && last_bit_s;
    busy      = w_valid || hold_full_q;
  end

  // Next-state logic for the control FSM and the shift/hold datapath.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!last_bit_s) begin
          // Mid-word: advance one bit; a new word can only go to hold.
          sh_d  = sh_shifted_s;
          cnt_d = cnt_q + CW'(1);
          if (accept_s) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end else if (hold_full_q) begin
          // Last bit with a queued word: chain it in without a gap.
          sh_d        = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept_s) begin
          // Last bit, hold empty, word offered now: load it straight in.
          sh_d  = din;
          cnt_d = '0;
        end else begin
          // Nothing queued: go quiet and let w return to the idle level.
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end
    endcase
  end

  // State registers; Reset aborts any word in flight and drops the held word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a cycle table covering back-to-back,
// backpressure and bypass streaming, plus short sequences for single words,
// LSB-first order and reset in the middle of a word.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, w, w_valid, word_done, busy;
  logic [7:0] l_din;
  logic       l_din_valid;
  logic       l_din_ready, l_w, l_w_valid, l_word_done, l_busy;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .Clock(Clock), .Reset(Reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .w(w), .w_valid(w_valid),
    .word_done(word_done), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .Clock(Clock), .Reset(Reset), .din(l_din), .din_valid(l_din_valid),
    .din_ready(l_din_ready), .w(l_w), .w_valid(l_w_valid),
    .word_done(l_word_done), .busy(l_busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Downstream Moore detector on the MSB-first line: z after three 1s.
  logic [1:0] det_q;
  logic       z;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) det_q <= DET_S0;
    else if (!w) det_q <= DET_S0;
    else begin
      case (det_q)
        DET_S0:  det_q <= DET_S1;
        DET_S1:  det_q <= DET_S2;
        default: det_q <= DET_S3;
      endcase
    end
  end
  assign z = (det_q == DET_S3);

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy, w, wv, wd, busy, z;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic rdy,
                     input logic ew, input logic wv, input logic wd,
                     input logic bz, input logic ez);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.w = ew; r.wv = wv; r.wd = wd;
    r.busy = bz; r.z = ez;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    int   wv_count;
    logic [7:0] word;

    // Row i: outputs seen during cycle i, inputs applied for the edge ending it.
    // A5 then 3C back-to-back, 81 waits under backpressure, 0F arrives on 81's
    // last-bit edge with hold empty (bypass).
    //   v     din    rdy   w     wv    wd    busy  z
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // r0 idle, accept A5
    add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r1 A5 b7, 3C -> hold
    add(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r2
    add(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r3
    add(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r4
    add(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r5
    add(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r6
    add(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r7
    add(1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // r8 A5 last bit
    add(1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r9 3C b7, 81 -> hold
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r10
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r11
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r12
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r13
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // r14 z in 1111 run
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); // r15
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // r16 3C last bit
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r17 81 b7
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r18
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r19
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r20
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r21
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r22
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r23
    add(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // r24 81 last, bypass 0F
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r25 0F b7, hold empty
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r26
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r27
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); // r28
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r29
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r30
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // r31
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // r32 0F last bit
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // r33 idle again
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // r34

    // Reset with din offered: din must be ignored.
    Reset = 1'b1; din_valid = 1'b1; din = 8'hFF;
    l_din_valid = 1'b0; l_din = 8'h00;
    repeat (3) @(negedge Clock);
    check("rst w", w, 1'b0);
    check("rst w_valid", w_valid, 1'b0);
    check("rst word_done", word_done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst din_ready", din_ready, 1'b1);
    Reset = 1'b0; din_valid = 1'b0; din = 8'h00;
    @(negedge Clock);
    check("post-rst no word", w_valid, 1'b0);

    // Table-driven stream.
    wv_count = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      check($sformatf("r%0d din_ready", i), din_ready, vecs[i].rdy);
      check($sformatf("r%0d w", i), w, vecs[i].w);
      check($sformatf("r%0d w_valid", i), w_valid, vecs[i].wv);
      check($sformatf("r%0d word_done", i), word_done, vecs[i].wd);
      check($sformatf("r%0d busy", i), busy, vecs[i].busy);
      check($sformatf("r%0d z", i), z, vecs[i].z);
      if (w_valid) wv_count++;
      din_valid = vecs[i].v;
      din = vecs[i].d;
    end
    check("stream w_valid cycles", wv_count, 32);

    // Single word C3, MSB first.
    word = 8'hC3;
    din_valid = 1'b1; din = word;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      din_valid = 1'b0;
      check($sformatf("c3 w bit%0d", k), w, word[7-k]);
      check($sformatf("c3 w_valid %0d", k), w_valid, 1'b1);
      check($sformatf("c3 word_done %0d", k), word_done, (k == 7) ? 1'b1 : 1'b0);
    end
    @(negedge Clock);
    check("c3 after w", w, 1'b0);
    check("c3 after w_valid", w_valid, 1'b0);
    check("c3 after busy", busy, 1'b0);

    // LSB-first instance, word 01.
    word = 8'h01;
    l_din_valid = 1'b1; l_din = word;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      l_din_valid = 1'b0;
      check($sformatf("lsb w bit%0d", k), l_w, word[k]);
      check($sformatf("lsb w_valid %0d", k), l_w_valid, 1'b1);
    end
    @(negedge Clock);
    check("lsb after w_valid", l_w_valid, 1'b0);
    check("lsb after busy", l_busy, 1'b0);

    // Reset in the middle of an FF word, with a second word queued.
    din_valid = 1'b1; din = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      din = 8'hF0;
      if (k == 1) din_valid = 1'b0;
      check($sformatf("mid w bit%0d", k), w, 1'b1);
    end
    check("mid busy", busy, 1'b1);
    #2 Reset = 1'b1;
    din_valid = 1'b1; din = 8'hFF;
    #1;
    check("mid rst w", w, 1'b0);
    check("mid rst w_valid", w_valid, 1'b0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst din_ready", din_ready, 1'b1);
    @(negedge Clock);
    Reset = 1'b0; din_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      check($sformatf("post-mid w_valid %0d", k), w_valid, 1'b0);
      check($sformatf("post-mid w %0d", k), w, 1'b0);
    end
    check("post-mid busy", busy, 1'b0);
    check("post-mid din_ready", din_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end. Accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per Clock onto the single-bit line w.
- w feeds the downstream Moore sequence detector that raises z after consecutive 1s.
- A one-word holding register lets back-to-back words stream with no idle gap between their bits.

Parameters:
WIDTH, 8, word width in bits (WIDTH >= 2)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first
IDLE_LEVEL, 0, value driven on w when no word is being shifted

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept din this cycle
w  output  1  serial bit to downstream detector
w_valid  output  1  w carries a data bit this cycle
word_done  output  1  current bit on w is the last bit of its word
busy  output  1  a word is shifting or one is held

Behaviour:
- State machine: IDLE, SHIFT. Shifter register sh[WIDTH-1:0], bit counter cnt (width clog2(WIDTH)), holding register hold[WIDTH-1:0], flag hold_full.
- Reset (async, active-high) forces:
  - state = IDLE, cnt = 0, sh = 0, hold_full = 0, hold = 0.
  - Output values: w = IDLE_LEVEL, w_valid = 0, word_done = 0, busy = 0, din_ready = 1.
  - din is ignored while Reset is high.
- Reset mid-word aborts the word and discards the held word. There is no partial-word completion.
- Combinational outputs:
  - din_ready = !hold_full.
  - w_valid = (state == SHIFT).
  - w = w_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_LEVEL.
  - word_done = w_valid && cnt == WIDTH-1.
  - busy = w_valid || hold_full.
- An accept is din_valid && din_ready at a rising edge.
- IDLE:
  - On accept: sh <= din, cnt <= 0, state <= SHIFT.
  - Latency: the first bit is on w in the cycle after the accepting edge.
- SHIFT, edge with cnt < WIDTH-1:
  - Shift sh toward the output end (left if MSB_FIRST, else right); the vacated bit fills with 0.
  - cnt <= cnt+1.
  - An accept in this case loads hold and sets hold_full.
- SHIFT, edge with cnt == WIDTH-1 (last bit):
  - hold_full = 1: sh <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT. The next word's first bit follows with no gap.
  - hold_full = 0 with an accept on the same edge: sh <= din directly (bypassing hold), cnt <= 0, stay in SHIFT.
  - Otherwise: state <= IDLE, w returns to IDLE_LEVEL.
- Each word occupies exactly WIDTH consecutive w_valid cycles.
- Sustained throughput is one word per WIDTH cycles. din_ready deasserts while hold is occupied.
- din must be held stable only at the accepting edge. No combinational path exists from din_valid to din_ready.
- Downstream view:
  - The detector samples w every cycle and is not gated by w_valid.
  - With IDLE_LEVEL = 0, idle gaps break 1-runs.
  - A run of 1s spanning two back-to-back words is continuous on w.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, SHIFT}, 1-bit encoding;
  - default constants for WIDTH and IDLE_LEVEL;
  - the clog2-based counter-width helper.
- The same package holds the detector's state constants so both stages share one source.
- No sub-module is required. The shift/hold datapath is small enough to stay inline.

Test Plan:
- Reset mid-word: accept 8'hFF, assert Reset after 3 bits → w = 0 and w_valid = 0 immediately. After release, busy = 0, din_ready = 1, and no stale bits appear.
- Single word: MSB_FIRST = 1, accept din = 8'hC3 → from next cycle w = 1,1,0,0,0,0,1,1 with w_valid high for 8 cycles. word_done is high only on the 8th. Then w = 0, busy = 0.
- LSB order: MSB_FIRST = 0, din = 8'h01 → w = 1 then seven 0s.
- Back-to-back: hold din_valid with 8'hA5 then 8'h3C → 16 contiguous w_valid cycles: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - din_ready drops after the second accept and rises after the last-bit edge of word 1.
  - The downstream detector's z asserts during the 1,1,1,1 run.
- Bypass: offer a word exactly on the last-bit edge with hold empty → the new word starts next cycle, hold_full stays 0, no gap.
- Backpressure: three words offered continuously → the third waits (din_ready = 0) until the first completes. No word is lost or duplicated; total 24 w_valid cycles.
